dualport_rom_hs: RTL and testbench
==================================

DUALPORT_ROM_HS -- requirements
Module: dualport_rom_hs

Interface
REQ-001 Parameter DATA_W, default 8: width of each ROM word in bits, range 4..32.
REQ-002 Parameter ADDR_W, default 3: address width in bits; DEPTH = 2**ADDR_W words.
REQ-003 Parameter INIT_OFFSET, default 3: content offset; word[a] = (a + INIT_OFFSET) mod 2**DATA_W.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid_a / req_valid_b  input  1  port A/B read request present.
REQ-007 req_addr_a / req_addr_b  input  ADDR_W  port A/B read address.
REQ-008 req_ready_a / req_ready_b  output  1  port A/B can accept a request this cycle.
REQ-009 resp_valid_a / resp_valid_b  output  1  port A/B response word available.
REQ-010 resp_data_a / resp_data_b  output  DATA_W  port A/B response word.
REQ-011 resp_ready_a / resp_ready_b  input  1  port A/B consumer takes the response this cycle.
REQ-012 resp_par_a / resp_par_b  output  1  even parity of resp_data; present only with ROM_PARITY_EN.

Function
REQ-013 Ports A and B shall be fully independent; no shared state, no arbitration, same address on both ports in the same cycle legal.
REQ-014 A request shall be accepted on a rising edge where req_valid && req_ready; a response shall be popped on a rising edge where resp_valid && resp_ready.
REQ-015 Each port shall hold a 2-entry response FIFO with occupancy count 0..2.
REQ-016 On accept, word[req_addr] shall be written into the FIFO at the same edge; resp_valid shall assert in the following cycle (latency 1).
REQ-017 req_ready shall be (count < 2), registered-state-derived only; it shall not depend combinationally on resp_ready.
REQ-018 resp_valid shall be (count != 0); resp_data shall show the head entry when resp_valid, else all zeros.
REQ-019 Simultaneous accept and pop shall leave count unchanged; with count == 1 and resp_ready held high, one accept per cycle is sustained.
REQ-020 Responses shall be returned in request order per port; resp_data shall stay stable while resp_valid && !resp_ready.
REQ-021 req_addr shall be sampled only on accept; changes while req_ready is low have no effect.
REQ-022 Content arithmetic shall be (a + INIT_OFFSET) truncated to DATA_W bits; wrap-around is silent.

Reset
REQ-023 While rst is high at a rising edge, both FIFOs shall empty: count = 0, read/write pointers = 0.
REQ-024 After reset: resp_valid = 0, resp_data = 0, req_ready = 1, resp_par = 0.
REQ-025 A request presented in a cycle with rst high shall be dropped, not accepted; in-flight responses shall be discarded.

Configuration
REQ-026 Macro ROM_PARITY_EN defined: resp_par_a/b shall exist and equal the XOR of resp_data bits (0 when resp_valid = 0).
REQ-027 Macro ROM_PARITY_EN undefined: resp_par_a/b ports shall be absent; all other behaviour identical.

Structure
REQ-028 Shared package rom_pkg shall hold the default DATA_W/ADDR_W/INIT_OFFSET constants and the content function rom_word(addr).
REQ-029 One sub-module, rom_port (lookup + 2-entry FIFO + handshake), shall be instantiated twice, once per port.

Verification
REQ-030 Reset then idle: rst high 2 cycles -> resp_valid_a/b = 0, resp_data = 0x00, req_ready_a/b = 1.
REQ-031 Single read: port A addr 3 accepted at edge t -> resp_valid_a = 1, resp_data_a = 0x06 after edge t; pop at next edge -> resp_valid_a = 0.
REQ-032 Backpressure: resp_ready_b = 0, requests addr 0,1,2 back-to-back -> first two accepted, req_ready_b = 0 on third; release -> 0x03, 0x04 in order, then addr 2 accepted -> 0x05.
REQ-033 Streaming both ports: resp_ready high, A sweeps addr 0..7, B sweeps 7..0 -> one response per cycle each; A 0x03..0x0A, B 0x0A..0x03.
REQ-034 Wrap-around: DATA_W = 4, INIT_OFFSET = 14, addr 3 -> resp_data = 0x1 (17 mod 16).
REQ-035 Reset mid-operation: FIFO full, rst high one cycle -> count 0, resp_valid low, queued words never emitted; ROM_PARITY_EN build: resp 0x07 -> resp_par = 1.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared constants and content function for the dual-port handshake ROM.
// Build option: define ROM_PARITY_EN to add even-parity response outputs.
package rom_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ADDR_W      = 3;
  localparam int DEF_INIT_OFFSET = 3;

  localparam int FIFO_DEPTH = 2;

  // Untruncated content value; callers keep the low DATA_W bits so wrap-around is silent.
  function automatic logic [31:0] rom_word(input logic [31:0] addr,
                                           input logic [31:0] offset = DEF_INIT_OFFSET);
    return addr + offset;
  endfunction

endpackage

// File: rtl/rom_port.sv
// One read port: constant ROM lookup feeding a 2-entry response FIFO with
// valid/ready handshakes on both the request and the response side.
module rom_port
  import rom_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INIT_OFFSET = DEF_INIT_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  input  logic              resp_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rom_mem [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      localparam logic [31:0] WORD_FULL = rom_word(gi, INIT_OFFSET);
      assign rom_mem[gi] = WORD_FULL[DATA_W-1:0];
    end
  endgenerate

  logic [DATA_W-1:0] fifo_mem_reg [FIFO_DEPTH];
  logic              wr_ptr_reg;
  logic              wr_ptr_next;
  logic              rd_ptr_reg;
  logic              rd_ptr_next;
  logic [1:0]        count_reg;
  logic [1:0]        count_next;

  logic accept;
  logic pop;

  // Ready comes only from registered occupancy so there is no path from resp_ready.
  assign req_ready  = (count_reg != 2'd2);
  assign resp_valid = (count_reg != 2'd0);
  assign resp_data  = resp_valid ? fifo_mem_reg[rd_ptr_reg] : '0;

  assign accept = req_valid && req_ready;
  assign pop    = resp_valid && resp_ready;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (accept) begin
      wr_ptr_next = ~wr_ptr_reg;
    end
    if (pop) begin
      rd_ptr_next = ~rd_ptr_reg;
    end
    if (accept && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (pop && !accept) begin
      count_next = count_reg - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      fifo_mem_reg[wr_ptr_reg] <= rom_mem[req_addr];
    end
  end

endmodule

// File: rtl/dualport_rom_hs.sv
// Dual-port handshake ROM: two fully independent rom_port instances.
// Build option: ROM_PARITY_EN adds resp_par_a/resp_par_b (even parity of resp_data).
module dualport_rom_hs
  import rom_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INIT_OFFSET = DEF_INIT_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_a,
  input  logic [ADDR_W-1:0] req_addr_a,
  output logic              req_ready_a,
  output logic              resp_valid_a,
  output logic [DATA_W-1:0] resp_data_a,
  input  logic              resp_ready_a,
`ifdef ROM_PARITY_EN
  output logic              resp_par_a,
  output logic              resp_par_b,
`endif
  input  logic              req_valid_b,
  input  logic [ADDR_W-1:0] req_addr_b,
  output logic              req_ready_b,
  output logic              resp_valid_b,
  output logic [DATA_W-1:0] resp_data_b,
  input  logic              resp_ready_b
);

  rom_port #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .INIT_OFFSET (INIT_OFFSET)
  ) u_port_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid_a),
    .req_addr   (req_addr_a),
    .req_ready  (req_ready_a),
    .resp_valid (resp_valid_a),
    .resp_data  (resp_data_a),
    .resp_ready (resp_ready_a)
  );

  rom_port #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .INIT_OFFSET (INIT_OFFSET)
  ) u_port_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid_b),
    .req_addr   (req_addr_b),
    .req_ready  (req_ready_b),
    .resp_valid (resp_valid_b),
    .resp_data  (resp_data_b),
    .resp_ready (resp_ready_b)
  );

`ifdef ROM_PARITY_EN
  // resp_data is zero when invalid, so parity is naturally 0 then.
  assign resp_par_a = ^resp_data_a;
  assign resp_par_b = ^resp_data_b;
`endif

endmodule

// File: tb/tb_dualport_rom_hs.sv
// Directed bench for dualport_rom_hs: default instance plus a 4-bit wrap-around instance.
module tb_dualport_rom_hs;

  logic clk = 1'b0;
  logic rst;

  logic       req_valid_a, req_valid_b, resp_ready_a, resp_ready_b;
  logic [2:0] req_addr_a, req_addr_b;
  logic       req_ready_a, req_ready_b, resp_valid_a, resp_valid_b;
  logic [7:0] resp_data_a, resp_data_b;

  logic       w_req_valid_a, w_req_valid_b, w_resp_ready_a, w_resp_ready_b;
  logic [2:0] w_req_addr_a, w_req_addr_b;
  logic       w_req_ready_a, w_req_ready_b, w_resp_valid_a, w_resp_valid_b;
  logic [3:0] w_resp_data_a, w_resp_data_b;

`ifdef ROM_PARITY_EN
  logic resp_par_a, resp_par_b, w_resp_par_a, w_resp_par_b;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dualport_rom_hs #(.DATA_W(8), .ADDR_W(3), .INIT_OFFSET(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_a  (req_valid_a),
    .req_addr_a   (req_addr_a),
    .req_ready_a  (req_ready_a),
    .resp_valid_a (resp_valid_a),
    .resp_data_a  (resp_data_a),
    .resp_ready_a (resp_ready_a),
`ifdef ROM_PARITY_EN
    .resp_par_a   (resp_par_a),
    .resp_par_b   (resp_par_b),
`endif
    .req_valid_b  (req_valid_b),
    .req_addr_b   (req_addr_b),
    .req_ready_b  (req_ready_b),
    .resp_valid_b (resp_valid_b),
    .resp_data_b  (resp_data_b),
    .resp_ready_b (resp_ready_b)
  );

  dualport_rom_hs #(.DATA_W(4), .ADDR_W(3), .INIT_OFFSET(14)) dut_w (
    .clk          (clk),
    .rst          (rst),
    .req_valid_a  (w_req_valid_a),
    .req_addr_a   (w_req_addr_a),
    .req_ready_a  (w_req_ready_a),
    .resp_valid_a (w_resp_valid_a),
    .resp_data_a  (w_resp_data_a),
    .resp_ready_a (w_resp_ready_a),
`ifdef ROM_PARITY_EN
    .resp_par_a   (w_resp_par_a),
    .resp_par_b   (w_resp_par_b),
`endif
    .req_valid_b  (w_req_valid_b),
    .req_addr_b   (w_req_addr_b),
    .req_ready_b  (w_req_ready_b),
    .resp_valid_b (w_resp_valid_b),
    .resp_data_b  (w_resp_data_b),
    .resp_ready_b (w_resp_ready_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid_a = 0; req_valid_b = 0; req_addr_a = 0; req_addr_b = 0;
    resp_ready_a = 0; resp_ready_b = 0;
    w_req_valid_a = 0; w_req_valid_b = 0; w_req_addr_a = 0; w_req_addr_b = 0;
    w_resp_ready_a = 0; w_resp_ready_b = 0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    check("rst_valid_a", 32'(resp_valid_a), 32'd0);
    check("rst_valid_b", 32'(resp_valid_b), 32'd0);
    check("rst_data_a",  32'(resp_data_a),  32'h00);
    check("rst_data_b",  32'(resp_data_b),  32'h00);
    check("rst_ready_a", 32'(req_ready_a),  32'd1);
    check("rst_ready_b", 32'(req_ready_b),  32'd1);
`ifdef ROM_PARITY_EN
    check("rst_par_a",   32'(resp_par_a),   32'd0);
`endif

    // Single read on port A
    req_valid_a = 1; req_addr_a = 3;
    tick();
    req_valid_a = 0;
    check("single_valid", 32'(resp_valid_a), 32'd1);
    check("single_data",  32'(resp_data_a),  32'h06);
    resp_ready_a = 1;
    tick();
    resp_ready_a = 0;
    check("single_pop_valid", 32'(resp_valid_a), 32'd0);
    check("single_pop_data",  32'(resp_data_a),  32'h00);

    // Backpressure on port B
    req_valid_b = 1; req_addr_b = 0;
    tick();
    req_addr_b = 1;
    tick();
    req_addr_b = 2;
    check("bp_ready_full", 32'(req_ready_b), 32'd0);
    check("bp_head",       32'(resp_data_b), 32'h03);
    req_addr_b = 7;  // ignored while not ready
    tick();
    check("bp_hold_data",  32'(resp_data_b), 32'h03);
    check("bp_hold_ready", 32'(req_ready_b), 32'd0);
    req_addr_b = 2;
    resp_ready_b = 1;
    tick();
    check("bp_second", 32'(resp_data_b), 32'h04);
    check("bp_ready_again", 32'(req_ready_b), 32'd1);
    tick();
    req_valid_b = 0;
    check("bp_third", 32'(resp_data_b), 32'h05);
    tick();
    check("bp_drained", 32'(resp_valid_b), 32'd0);

    // Streaming both ports
    resp_ready_a = 1; resp_ready_b = 1;
    req_valid_a = 1; req_valid_b = 1;
    for (int i = 0; i < 8; i++) begin
      req_addr_a = 3'(i);
      req_addr_b = 3'(7 - i);
      tick();
      check($sformatf("stream_a_%0d", i), 32'(resp_data_a), 32'(i + 3));
      check($sformatf("stream_b_%0d", i), 32'(resp_data_b), 32'(10 - i));
      check($sformatf("stream_rdy_%0d", i), 32'({req_ready_a, req_ready_b}), 32'b11);
    end
    req_valid_a = 0; req_valid_b = 0;
    tick();
    check("stream_end_a", 32'(resp_valid_a), 32'd0);
    check("stream_end_b", 32'(resp_valid_b), 32'd0);
    resp_ready_a = 0; resp_ready_b = 0;

    // Wrap-around on the 4-bit instance
    w_req_valid_a = 1; w_req_addr_a = 3;
    w_req_valid_b = 1; w_req_addr_b = 1;
    w_resp_ready_a = 1; w_resp_ready_b = 1;
    tick();
    w_req_valid_a = 0; w_req_valid_b = 0;
    check("wrap_a3", 32'(w_resp_data_a), 32'h1);
    check("wrap_b1", 32'(w_resp_data_b), 32'hF);
    tick();

    // Reset mid-operation with a full FIFO
    req_valid_a = 1; req_addr_a = 4;
    tick();
    req_addr_a = 5;
    tick();
    check("full_ready", 32'(req_ready_a), 32'd0);
    req_addr_a = 6;
    rst = 1;
    tick();
    rst = 0;
    req_valid_a = 0;
    check("mid_rst_valid", 32'(resp_valid_a), 32'd0);
    check("mid_rst_data",  32'(resp_data_a),  32'h00);
    check("mid_rst_ready", 32'(req_ready_a),  32'd1);
    resp_ready_a = 1;
    tick();
    check("mid_rst_dropped", 32'(resp_valid_a), 32'd0);
    req_valid_a = 1; req_addr_a = 4;
    tick();
    req_valid_a = 0;
    check("post_rst_data", 32'(resp_data_a), 32'h07);
`ifdef ROM_PARITY_EN
    check("post_rst_par",  32'(resp_par_a),  32'd1);
`endif
    tick();
    check("post_rst_empty", 32'(resp_valid_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
